mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multicycle MIPS main control unit. It sequences the shared ALU, the register file, memory, IR and PC over multiple cycles per instruction. It drives ALUOp into the ALU control decoder and presents a valid/ready handshake to a variable-latency unified memory. The block sits between the IR opcode field and all datapath mux/enable controls.

Parameters:
STATE_W, 4, width of state register and debug state output
TRAP_VECTOR_SEL, 2'b11, PCSource value driven in TRAP state (used only when the optional feature is on)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR
IRWrite  output  1  IR load
PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = trap
ALUOp  output  2  00 = add, 01 = sub, 10 = R-type funct decode
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
RegWrite  output  1  register file write enable
RegDst  output  1  0 = rt, 1 = rd
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
illegal_op  output  1  sticky illegal-opcode flag (feature-dependent)
state_dbg  output  STATE_W  current state encoding

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, all outputs 0, illegal_op=0.
- Output style: Moore decode of the registered state. Exceptions: IRWrite and PCWrite in FETCH, and the MEMRD->MEMWB / MEMWR advance, are qualified by mem_ready.
- States and encodings, with non-listed outputs 0:
  - IDLE (0): all outputs 0 -> FETCH.
  - FETCH (1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stays while mem_ready=0 -> DECODE.
  - DECODE (2): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Branches on opcode:
    - 000000 -> REXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BEQ
    - 000010 -> JUMP
    - 001000 -> IEXEC
    - other -> see Optional Feature
  - MEMADR (3): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD if lw, MEMWR if sw.
  - MEMRD (4): MemRead=1, IorD=1. Stays while mem_ready=0 -> MEMWB.
  - MEMWB (5): RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1 -> FETCH.
  - MEMWR (6): MemWrite=1, IorD=1, instr_done=mem_ready. Stays while mem_ready=0 -> FETCH.
  - REXEC (7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
  - RWB (8): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
  - BEQ (9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
  - JUMP (10): PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
  - IEXEC (11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IWB.
  - IWB (12): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
  - TRAP (13): described under Optional Feature.
- Instruction latency with mem_ready held at 1: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Each cycle of mem_ready=0 in a memory state adds one cycle.
- MemRead and MemWrite are never both 1. MemRead/MemWrite stay asserted until accepted.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- opcode is sampled only in DECODE and MEMADR. The IR is stable in those states because IRWrite=0 there.
- Unused encodings 14-15 -> IDLE next cycle, all outputs 0.
- Reset asserted mid-instruction: immediate return to IDLE. No partial writes occur after the reset edge.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP drives PCWrite=1, PCSource=TRAP_VECTOR_SEL and instr_done=1, sets illegal_op=1, then -> FETCH. illegal_op stays set until reset.
- Undefined: an unknown opcode in DECODE -> FETCH, treated as a NOP with instr_done=1 in DECODE. TRAP is unreachable and illegal_op is tied to 0.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> all outputs 0 and state_dbg=0 during reset; state_dbg=1 with MemRead=1 on the cycle after release.
- R-type: opcode=000000, mem_ready=1 -> states 1,2,7,8. ALUOp=10 in state 7. RegWrite=1, RegDst=1 and instr_done=1 in state 8. Total 4 cycles.
- lw with memory stall: opcode=100011, mem_ready=0 for 2 cycles in MEMRD -> states 1,2,3,4,4,4,5. MemRead/IorD held at 1 throughout the stall. MemtoReg=1 and RegWrite=1 in state 5.
- beq and j back-to-back: opcode=000100 -> PCWriteCond=1, ALUOp=01, PCSource=01 in state 9. Then opcode=000010 -> PCWrite=1, PCSource=10 in state 10. Each instruction takes 3 cycles.
- Illegal opcode 111111:
  - with MC_CTRL_ILLEGAL_TRAP_EN -> state 13, PCSource=11, illegal_op stays 1 afterwards.
  - without the macro -> DECODE -> FETCH, illegal_op=0.
- Reset mid-sw: assert rst_n=0 while in MEMWR with mem_ready=0 -> MemWrite drops to 0 asynchronously and state_dbg=0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences PC, IR, memory, register file and ALU controls.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to route unknown opcodes to a TRAP state.
module mc_ctrl_fsm #(
  parameter int         STATE_W         = 4,
  parameter logic [1:0] TRAP_VECTOR_SEL = 2'b11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_REXEC  = 4'd7,
    S_RWB    = 4'd8,  S_BEQ   = 4'd9,  S_JUMP   = 4'd10, S_IEXEC  = 4'd11,
    S_IWB    = 4'd12, S_TRAP  = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       done;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Moore control word for a state; mem_ready-qualified terms are added at the outputs.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: begin c.alu_src_b = 2'b11; end
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_REXEC:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
      S_BEQ:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.done = 1'b1;
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1; end
      S_IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_IWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
      S_TRAP:   begin c.pc_write = 1'b1; c.pc_source = TRAP_VECTOR_SEL; c.done = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_next;
  logic   w_nop_done;
  logic   w_fetch_ack;
  logic   w_wr_ack;

  // Next-state selection; opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    w_next     = S_IDLE;
    w_nop_done = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE; else w_next = S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_REXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_IEXEC;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next     = S_FETCH;
            w_nop_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: if (opcode == OP_LW) w_next = S_MEMRD; else w_next = S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB; else w_next = S_MEMRD;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH; else w_next = S_MEMWR;
      S_REXEC:  w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_IWB, S_TRAP: w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
`endif

  // State and control-word registers; the control word is pre-decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_decode(w_next);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      else                  r_illegal <= r_illegal;
`endif
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign w_fetch_ack = (r_state == S_FETCH) && mem_ready;
  assign w_wr_ack    = (r_state == S_MEMWR) && mem_ready;

  assign PCWrite     = r_ctrl.pc_write | w_fetch_ack;
  assign IRWrite     = w_fetch_ack;
  assign instr_done  = r_ctrl.done | w_wr_ack | w_nop_done;
  assign PCWriteCond = r_ctrl.pc_write_cond;
  assign IorD        = r_ctrl.iord;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign MemtoReg    = r_ctrl.mem_to_reg;
  assign PCSource    = r_ctrl.pc_source;
  assign ALUOp       = r_ctrl.alu_op;
  assign ALUSrcA     = r_ctrl.alu_src_a;
  assign ALUSrcB     = r_ctrl.alu_src_b;
  assign RegWrite    = r_ctrl.reg_write;
  assign RegDst      = r_ctrl.reg_dst;
  assign state_dbg   = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected state/controls queued at drive time, popped and compared.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [3:0] state_dbg;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        ill;
    logic [16:0] o;
  } rec_t;

  rec_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic tb_illegal = 1'b0;
  rec_t exp_r, got_r;

  // Reference control outputs for a state, written from the state table.
  function automatic logic [16:0] model(input int s, input logic mr, input logic [5:0] opc);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done;
    logic [1:0] pcs, aop, asb;
    logic known;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done} = 11'd0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    known = (opc == 6'b000000) || (opc == 6'b100011) || (opc == 6'b101011) ||
            (opc == 6'b000100) || (opc == 6'b000010) || (opc == 6'b001000);
    case (s)
      1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      2:  begin
        asb = 2'b11;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        if (!known) done = 1'b1;
`endif
      end
      3:  begin asa = 1'b1; asb = 2'b10; end
      4:  begin mrd = 1'b1; iord = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      6:  begin mwr = 1'b1; iord = 1'b1; done = mr; end
      7:  begin asa = 1'b1; aop = 2'b10; end
      8:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
      9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; done = 1'b1; end
      10: begin pcw = 1'b1; pcs = 2'b10; done = 1'b1; end
      11: begin asa = 1'b1; asb = 2'b10; end
      12: begin rw = 1'b1; done = 1'b1; end
      13: begin pcw = 1'b1; pcs = 2'b11; done = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, done};
  endfunction

  function automatic rec_t observed();
    return {state_dbg, illegal_op, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
            IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done};
  endfunction

  // Drive one cycle of inputs in the low phase and queue the expected observation.
  task automatic drive_cycle(input logic [5:0] opc, input logic mr, input int s);
    @(negedge clk);
    opcode = opc;
    mem_ready = mr;
    if (s == 13) tb_illegal = 1'b1;
    q.push_back({4'(s), tb_illegal, model(s, mr, opc)});
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(6'd0, 1'b1, 0);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
    #1 rst_n = 1'b1;
    drive_cycle(6'd0, 1'b0, 1);
    exp_r = q.pop_front(); got_r = observed(); n_tests++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL reset_release: got %h, expected %h", got_r, exp_r);
    end
  endtask

  task automatic test_rtype();
    int st[4] = '{1, 2, 7, 8};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(6'b000000, 1'b1, st[i]);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL rtype cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
  endtask

  task automatic test_lw_stall();
    int   st[7] = '{1, 2, 3, 4, 4, 4, 5};
    logic mr[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(6'b100011, mr[i], st[i]);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL lw_stall cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op[7] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
    logic       mr[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         st[7] = '{1, 2, 9, 1, 1, 2, 10};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(op[i], mr[i], st[i]);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL beq_j cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
  endtask

  task automatic test_addi();
    int st[4] = '{1, 2, 11, 12};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(6'b001000, 1'b1, st[i]);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL addi cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
  endtask

  task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam int N = 6;
    int         st[N] = '{1, 2, 13, 1, 2, 9};
    logic [5:0] op[N] = '{6'b111111, 6'b111111, 6'b111111, 6'b000100, 6'b000100, 6'b000100};
`else
    localparam int N = 5;
    int         st[N] = '{1, 2, 1, 2, 9};
    logic [5:0] op[N] = '{6'b111111, 6'b111111, 6'b000100, 6'b000100, 6'b000100};
`endif
    for (int i = 0; i < N; i++) begin
      drive_cycle(op[i], 1'b1, st[i]);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL illegal cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
  endtask

  task automatic test_sw_reset();
    int   st[8] = '{1, 2, 3, 6, 6, 1, 2, 3};
    logic mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(6'b101011, mr[i], st[i]);
      exp_r = q.pop_front(); got_r = observed(); n_tests++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL sw cyc%0d: got %h, expected %h", i, got_r, exp_r);
      end
    end
    drive_cycle(6'b101011, 1'b0, 6);
    exp_r = q.pop_front(); got_r = observed(); n_tests++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL sw_stall: got %h, expected %h", got_r, exp_r);
    end
    #1 rst_n = 1'b0;
    tb_illegal = 1'b0;
    q.push_back({4'd0, 1'b0, 17'd0});
    #1;
    exp_r = q.pop_front(); got_r = observed(); n_tests++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL sw_async_reset: got %h (MemWrite=%b), expected %h", got_r, MemWrite, exp_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(6'd0, 1'b0, 1);
    exp_r = q.pop_front(); got_r = observed(); n_tests++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL post_reset_fetch: got %h, expected %h", got_r, exp_r);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_back_to_back();
    test_addi();
    test_illegal();
    test_sw_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
